memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/memory_arbiter_if.sv | 40 ++++
 rtl/sat_counter.sv | 23 ++
 rtl/memory_arbiter.sv | 125 ++++++++++++
 tb/tb_memory_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: bus word, memory-arbiter state encoding, word alignment.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    IACC,
    DACC,
    IDONE,
    DDONE
  } memstate_t;

  localparam word_t WORD_MASK = 32'hFFFF_FFFC;

  // Clear the byte offset so the RAM always sees a word address.
  function automatic word_t word_align(input word_t addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Datapath/RAM bus seen by the memory arbiter. Signal names match the legacy ports.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  // datapath side
  logic  imemREN;
  word_t imemaddr;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  halt;
  logic  ihit;
  logic  dhit;
  word_t imemload;
  word_t dmemload;

  // RAM side
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ramready;

  // Arbiter view
  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
           ramload, ramready,
    output ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Datapath + RAM view
  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
           ramload, ramready,
    input  ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count enabled events, stopping at the maximum value instead of wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates one RAM port between instruction fetch and data access.
// Data wins ties; an access may be abandoned if its request drops before ramready.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]  icount,
  output logic [CNT_W-1:0]  dcount,
  output logic [CNT_W-1:0]  stallcount
);

  memstate_t state_q;
  memstate_t state_d;

  logic data_req;
  logic stall_en;
  logic freeze;

  assign data_req = bus.dmemREN | bus.dmemWEN;

  // State register; reset discards any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and RAM strobe/address decode.
  always_comb begin
    state_d      = state_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    unique case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d = DACC;
        end else if (bus.imemREN && !bus.halt) begin
          state_d = IACC;
        end
      end
      IACC: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = word_align(bus.imemaddr);
        if (!bus.imemREN) begin
          state_d = IDLE;
        end else if (bus.ramready) begin
          state_d = IDONE;
        end
      end
      DACC: begin
        bus.ramREN   = bus.dmemREN;
        bus.ramWEN   = bus.dmemWEN & ~bus.dmemREN;
        bus.ramaddr  = word_align(bus.dmemaddr);
        bus.ramstore = bus.dmemstore;
        if (!data_req) begin
          state_d = IDLE;
        end else if (bus.ramready) begin
          state_d = DDONE;
        end
      end
      IDONE, DDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hit pulses last exactly the one DONE cycle.
  assign bus.ihit = (state_q == IDONE);
  assign bus.dhit = (state_q == DDONE);

  // Capture read data only for a live (non-aborted) read completing this cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.imemload <= '0;
      bus.dmemload <= '0;
    end else begin
      if ((state_q == IACC) && bus.imemREN && bus.ramready) begin
        bus.imemload <= bus.ramload;
      end
      if ((state_q == DACC) && bus.dmemREN && bus.ramready) begin
        bus.dmemload <= bus.ramload;
      end
    end
  end

  // Counters hold while the halted datapath idles; stalls only occur mid-access.
  assign freeze   = bus.halt && (state_q == IDLE);
  assign stall_en = ((state_q == IACC) || (state_q == DACC)) && !bus.ramready;

  sat_counter #(.W(CNT_W)) u_icount (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (bus.ihit && !freeze),
    .clr   (1'b0),
    .count (icount)
  );

  sat_counter #(.W(CNT_W)) u_dcount (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (bus.dhit && !freeze),
    .clr   (1'b0),
    .count (dcount)
  );

  sat_counter #(.W(CNT_W)) u_stallcount (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (stall_en && !freeze),
    .clr   (1'b0),
    .count (stallcount)
  );

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (32-bit and 4-bit counter builds).
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  logic [31:0] icount, dcount, stallcount;
  logic [3:0]  icount4, dcount4, stallcount4;

  int checks = 0;
  int errors = 0;

  memory_arbiter_if bus ();
  memory_arbiter_if bus4 ();

  // Narrow-counter instance sees the same stimulus.
  assign bus4.imemREN   = bus.imemREN;
  assign bus4.imemaddr  = bus.imemaddr;
  assign bus4.dmemREN   = bus.dmemREN;
  assign bus4.dmemWEN   = bus.dmemWEN;
  assign bus4.dmemaddr  = bus.dmemaddr;
  assign bus4.dmemstore = bus.dmemstore;
  assign bus4.halt      = bus.halt;
  assign bus4.ramload   = bus.ramload;
  assign bus4.ramready  = bus.ramready;

  memory_arbiter #(.CNT_W(32)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus),
    .icount     (icount),
    .dcount     (dcount),
    .stallcount (stallcount)
  );

  memory_arbiter #(.CNT_W(4)) dut4 (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus4),
    .icount     (icount4),
    .dcount     (dcount4),
    .stallcount (stallcount4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.imemREN   = 1'b0;
    bus.imemaddr  = '0;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    bus.halt      = 1'b0;
    bus.ramload   = '0;
    bus.ramready  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 1'b0;
    #2;
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got=%b exp=0", bus.ihit); end
    checks++; if (bus.dhit !== 1'b0) begin errors++; $display("FAIL reset_dhit got=%b exp=0", bus.dhit); end
    checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {bus.ramREN, bus.ramWEN}); end
    checks++; if ({bus.imemload, bus.dmemload} !== 64'h0) begin errors++; $display("FAIL reset_loads got=%h exp=0", {bus.imemload, bus.dmemload}); end
    checks++; if ({icount, dcount, stallcount} !== 96'h0) begin errors++; $display("FAIL reset_counters got=%h exp=0", {icount, dcount, stallcount}); end
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    do_reset();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0006;
    tick();
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL fetch_ramREN got=%b exp=1", bus.ramREN); end
    checks++; if (bus.ramaddr !== 32'h4) begin errors++; $display("FAIL fetch_ramaddr got=%h exp=00000004", bus.ramaddr); end
    tick();
    tick();
    tick();
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL fetch_early_ihit got=%b exp=0", bus.ihit); end
    bus.ramready = 1'b1;
    bus.ramload  = 32'h3C01_0001;
    tick();
    checks++; if (bus.ihit !== 1'b1) begin errors++; $display("FAIL fetch_ihit got=%b exp=1", bus.ihit); end
    checks++; if (bus.imemload !== 32'h3C01_0001) begin errors++; $display("FAIL fetch_imemload got=%h exp=3c010001", bus.imemload); end
    bus.imemREN  = 1'b0;
    bus.ramready = 1'b0;
    tick();
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL fetch_ihit_width got=%b exp=0", bus.ihit); end
    checks++; if (icount !== 32'd1) begin errors++; $display("FAIL fetch_icount got=%0d exp=1", icount); end
    checks++; if (stallcount !== 32'd3) begin errors++; $display("FAIL fetch_stallcount got=%0d exp=3", stallcount); end
  endtask

  task automatic test_contention();
    do_reset();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0010;
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h0000_0047;
    tick();
    checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b10) begin errors++; $display("FAIL cont_dacc_strobes got=%b exp=10", {bus.ramREN, bus.ramWEN}); end
    checks++; if (bus.ramaddr !== 32'h44) begin errors++; $display("FAIL cont_dacc_addr got=%h exp=00000044", bus.ramaddr); end
    bus.ramready = 1'b1;
    bus.ramload  = 32'h1111_1111;
    tick();
    checks++; if ({bus.dhit, bus.ihit} !== 2'b10) begin errors++; $display("FAIL cont_dhit got=%b exp=10", {bus.dhit, bus.ihit}); end
    checks++; if (bus.dmemload !== 32'h1111_1111) begin errors++; $display("FAIL cont_dmemload got=%h exp=11111111", bus.dmemload); end
    bus.dmemREN  = 1'b0;
    bus.ramready = 1'b0;
    tick();
    checks++; if ({bus.dhit, bus.ihit, bus.ramREN} !== 3'b000) begin errors++; $display("FAIL cont_idle got=%b exp=000", {bus.dhit, bus.ihit, bus.ramREN}); end
    tick();
    checks++; if (bus.ramaddr !== 32'h10) begin errors++; $display("FAIL cont_iacc_addr got=%h exp=00000010", bus.ramaddr); end
    bus.ramready = 1'b1;
    bus.ramload  = 32'h2222_2222;
    tick();
    checks++; if (bus.ihit !== 1'b1) begin errors++; $display("FAIL cont_ihit got=%b exp=1", bus.ihit); end
    checks++; if (bus.imemload !== 32'h2222_2222) begin errors++; $display("FAIL cont_imemload got=%h exp=22222222", bus.imemload); end
    bus.imemREN  = 1'b0;
    bus.ramready = 1'b0;
    tick();
    checks++; if ({icount, dcount} !== {32'd1, 32'd1}) begin errors++; $display("FAIL cont_counts got=%0d/%0d exp=1/1", icount, dcount); end
  endtask

  // Runs after test_contention, so dmemload holds 0x11111111.
  task automatic test_write();
    bus.dmemWEN   = 1'b1;
    bus.dmemaddr  = 32'h0000_0080;
    bus.dmemstore = 32'hDEAD_BEEF;
    tick();
    checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b01) begin errors++; $display("FAIL write_strobes got=%b exp=01", {bus.ramREN, bus.ramWEN}); end
    checks++; if (bus.ramstore !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_ramstore got=%h exp=deadbeef", bus.ramstore); end
    checks++; if (bus.ramaddr !== 32'h80) begin errors++; $display("FAIL write_ramaddr got=%h exp=00000080", bus.ramaddr); end
    bus.ramready = 1'b1;
    bus.ramload  = 32'hBAD0_BAD0;
    tick();
    checks++; if (bus.dhit !== 1'b1) begin errors++; $display("FAIL write_dhit got=%b exp=1", bus.dhit); end
    checks++; if (bus.dmemload !== 32'h1111_1111) begin errors++; $display("FAIL write_dmemload got=%h exp=11111111", bus.dmemload); end
    checks++; if ({bus.ramREN, bus.ramWEN, bus.ramstore} !== 34'h0) begin errors++; $display("FAIL write_done_bus got=%h exp=0", {bus.ramREN, bus.ramWEN, bus.ramstore}); end
    bus.dmemWEN  = 1'b0;
    bus.ramready = 1'b0;
    tick();
    checks++; if (dcount !== 32'd2) begin errors++; $display("FAIL write_dcount got=%0d exp=2", dcount); end
  endtask

  // Runs after test_write: dcount=2, icount=1, stallcount=0.
  task automatic test_abort_halt();
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h0000_0020;
    tick();
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL abort_ramREN got=%b exp=1", bus.ramREN); end
    bus.dmemREN = 1'b0;
    bus.ramload = 32'h9999_9999;
    #1;
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("FAIL abort_drop_ramREN got=%b exp=0", bus.ramREN); end
    tick();
    checks++; if (bus.dhit !== 1'b0) begin errors++; $display("FAIL abort_dhit0 got=%b exp=0", bus.dhit); end
    tick();
    checks++; if (bus.dhit !== 1'b0) begin errors++; $display("FAIL abort_dhit1 got=%b exp=0", bus.dhit); end
    checks++; if (bus.dmemload !== 32'h1111_1111) begin errors++; $display("FAIL abort_dmemload got=%h exp=11111111", bus.dmemload); end
    checks++; if ({dcount, stallcount} !== {32'd2, 32'd1}) begin errors++; $display("FAIL abort_counts got=%0d/%0d exp=2/1", dcount, stallcount); end
    bus.halt     = 1'b1;
    bus.imemREN  = 1'b1;
    bus.ramready = 1'b1;
    tick();
    tick();
    tick();
    checks++; if ({bus.ramREN, bus.ihit} !== 2'b00) begin errors++; $display("FAIL halt_no_fetch got=%b exp=00", {bus.ramREN, bus.ihit}); end
    checks++; if ({icount, dcount, stallcount} !== {32'd1, 32'd2, 32'd1}) begin errors++; $display("FAIL halt_frozen got=%0d/%0d/%0d exp=1/2/1", icount, dcount, stallcount); end
    bus.imemREN  = 1'b0;
    bus.ramready = 1'b0;
    bus.halt     = 1'b0;
    tick();
  endtask

  task automatic test_halt_mid_fetch();
    do_reset();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0100;
    tick();
    bus.halt = 1'b1;
    tick();
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL halt_mid_ramREN got=%b exp=1", bus.ramREN); end
    bus.ramready = 1'b1;
    bus.ramload  = 32'h5555_5555;
    tick();
    checks++; if (bus.ihit !== 1'b1) begin errors++; $display("FAIL halt_mid_ihit got=%b exp=1", bus.ihit); end
    checks++; if (bus.imemload !== 32'h5555_5555) begin errors++; $display("FAIL halt_mid_imemload got=%h exp=55555555", bus.imemload); end
    bus.imemREN  = 1'b0;
    bus.ramready = 1'b0;
    tick();
    checks++; if ({icount, stallcount} !== {32'd1, 32'd1}) begin errors++; $display("FAIL halt_mid_counts got=%0d/%0d exp=1/1", icount, stallcount); end
    bus.halt = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0008;
    tick();
    tick();
    checks++; if ({bus.ramREN, stallcount} !== {1'b1, 32'd1}) begin errors++; $display("FAIL rst_mid_pre got=%h exp=100000001", {bus.ramREN, stallcount}); end
    #3;
    nRST = 1'b0;
    #1;
    checks++; if ({bus.ramREN, bus.ihit, bus.dhit} !== 3'b000) begin errors++; $display("FAIL rst_mid_async got=%b exp=000", {bus.ramREN, bus.ihit, bus.dhit}); end
    checks++; if ({icount, dcount, stallcount} !== 96'h0) begin errors++; $display("FAIL rst_mid_counters got=%h exp=0", {icount, dcount, stallcount}); end
    #2;
    nRST = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL rst_mid_no_ihit got=%b exp=0", bus.ihit); end
    bus.ramready = 1'b1;
    bus.ramload  = 32'h7777_7777;
    tick();
    checks++; if (bus.ihit !== 1'b1) begin errors++; $display("FAIL rst_mid_new_ihit got=%b exp=1", bus.ihit); end
    bus.imemREN  = 1'b0;
    bus.ramready = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'(i * 4);
      tick();
      bus.ramready = 1'b1;
      bus.ramload  = 32'(i);
      tick();
      bus.imemREN  = 1'b0;
      bus.ramready = 1'b0;
      tick();
    end
    checks++; if (icount4 !== 4'hF) begin errors++; $display("FAIL sat_icount4 got=%h exp=f", icount4); end
    checks++; if (icount !== 32'd17) begin errors++; $display("FAIL sat_icount32 got=%0d exp=17", icount); end
    checks++; if ({dcount4, stallcount4} !== 8'h00) begin errors++; $display("FAIL sat_other4 got=%h exp=00", {dcount4, stallcount4}); end
    checks++; if (bus4.imemload !== 32'd16) begin errors++; $display("FAIL sat_imemload4 got=%h exp=00000010", bus4.imemload); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_write();
    test_abort_halt();
    test_halt_mid_fetch();
    test_reset_mid_access();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
